// File: rtl/raymarch_stepper.sv
// Sphere-tracing step controller: issues p = o + t*d to a fixed-latency SDF and marches t until hit/miss.
// Optional build macro RAYMARCH_NEG_HIT_EN: any negative distance counts as a hit.
module raymarch_stepper #(
    parameter int unsigned SDF_LATENCY = 4,
    parameter int unsigned MAX_STEPS   = 64,
    parameter logic [26:0] EPS         = 27'h1D40000,
    parameter logic [26:0] T_MAX       = 27'h2100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ray_valid,
    output logic        o_ray_ready,
    input  logic [26:0] i_origin_x,
    input  logic [26:0] i_origin_y,
    input  logic [26:0] i_origin_z,
    input  logic [26:0] i_dir_x,
    input  logic [26:0] i_dir_y,
    input  logic [26:0] i_dir_z,
    output logic [26:0] o_point_x,
    output logic [26:0] o_point_y,
    output logic [26:0] o_point_z,
    output logic        o_point_valid,
    input  logic [26:0] i_distance,
    output logic        o_done_valid,
    input  logic        i_done_ready,
    output logic        o_hit,
    output logic [26:0] o_t,
    output logic [7:0]  o_steps
);

    // state    | meaning
    // S_IDLE   | waiting for a ray
    // S_POINT  | register p = o + t*d
    // S_ISSUE  | present p to the SDF for one cycle
    // S_WAIT   | count out the SDF latency, capture distance
    // S_UPDATE | hit / far-plane / step-limit decision, advance t
    // S_DONE   | hold result until consumed
    typedef enum logic [2:0] {S_IDLE, S_POINT, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

    localparam logic [7:0] LAT_M1    = 8'(SDF_LATENCY - 1);
    localparam logic [7:0] MAX_STEPS8 = 8'(MAX_STEPS);

    function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
        logic [37:0] prod;
        logic [10:0] e;
        logic [17:0] m;
        prod = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
        e    = {3'b0, a[25:18]} + {3'b0, b[25:18]} + {10'b0, prod[37]};
        m    = prod[37] ? prod[36:19] : prod[35:18];
        if (a[25:18] == 8'd0 || b[25:18] == 8'd0 || e <= 11'd127) return 27'h0;
        if (e >= 11'd382) return {a[26] ^ b[26], 8'hFE, 18'h3FFFF};
        return {a[26] ^ b[26], 8'(e - 11'd127), m};
    endfunction

    function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
        logic [26:0] x;
        logic [26:0] y;
        logic [7:0]  d;
        logic [21:0] sx;
        logic [21:0] sy;
        logic [22:0] sum;
        logic [21:0] norm;
        logic [4:0]  lz;
        if (b[25:18] == 8'd0) return (a[25:18] == 8'd0) ? 27'h0 : a;
        if (a[25:18] == 8'd0) return b;
        if (a[25:0] >= b[25:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[25:18] - y[25:18];
        sx = {1'b1, x[17:0], 3'b0};
        sy = (d > 8'd21) ? 22'h0 : ({1'b1, y[17:0], 3'b0} >> d);
        if (x[26] == y[26]) begin
            sum = {1'b0, sx} + {1'b0, sy};
            if (sum[22]) begin
                if (x[25:18] >= 8'd254) return {x[26], 8'hFE, 18'h3FFFF};
                return {x[26], x[25:18] + 8'd1, sum[21:4]};
            end
            return {x[26], x[25:18], sum[20:3]};
        end
        norm = sx - sy;
        if (norm == 22'h0) return 27'h0;
        lz = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (norm[i]) lz = 5'(21 - i);
        end
        if ({1'b0, x[25:18]} <= {4'b0, lz}) return 27'h0;
        norm = norm << lz;
        return {x[26], x[25:18] - 8'(lz), norm[20:3]};
    endfunction

    state_t      r_state;
    logic [26:0] r_ox, r_oy, r_oz, r_dx, r_dy, r_dz;
    logic [26:0] r_t, r_dist, r_t_out;
    logic [26:0] r_px, r_py, r_pz;
    logic [7:0]  r_cnt, r_steps;
    logic        r_ray_ready, r_point_valid, r_done_valid, r_hit;

    logic [26:0] w_px, w_py, w_pz, w_t_sum, w_t_next;
    logic        w_hit, w_far, w_last;

    assign w_px = fp_add(r_ox, fp_mul(r_t, r_dx));
    assign w_py = fp_add(r_oy, fp_mul(r_t, r_dy));
    assign w_pz = fp_add(r_oz, fp_mul(r_t, r_dz));

    // A negative distance can pull t below zero; the ray then restarts from its origin.
    assign w_t_sum  = fp_add(r_t, r_dist);
    assign w_t_next = w_t_sum[26] ? 27'h0 : w_t_sum;
    assign w_far    = w_t_next[25:0] > T_MAX[25:0];
    assign w_last   = (r_steps == MAX_STEPS8);

`ifdef RAYMARCH_NEG_HIT_EN
    assign w_hit = r_dist[26] | (r_dist[25:0] < EPS[25:0]);
`else
    assign w_hit = (r_dist[25:0] < EPS[25:0]);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ox <= 27'h0; r_oy <= 27'h0; r_oz <= 27'h0;
            r_dx <= 27'h0; r_dy <= 27'h0; r_dz <= 27'h0;
            r_px <= 27'h0; r_py <= 27'h0; r_pz <= 27'h0;
            r_t           <= 27'h0;
            r_dist        <= 27'h0;
            r_t_out       <= 27'h0;
            r_cnt         <= 8'd0;
            r_steps       <= 8'd0;
            r_ray_ready   <= 1'b1;
            r_point_valid <= 1'b0;
            r_done_valid  <= 1'b0;
            r_hit         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_ray_valid) begin
                    r_ox <= i_origin_x; r_oy <= i_origin_y; r_oz <= i_origin_z;
                    r_dx <= i_dir_x;    r_dy <= i_dir_y;    r_dz <= i_dir_z;
                    r_t         <= 27'h0;
                    r_steps     <= 8'd0;
                    r_ray_ready <= 1'b0;
                    r_state     <= S_POINT;
                end
                S_POINT: begin
                    r_px          <= w_px;
                    r_py          <= w_py;
                    r_pz          <= w_pz;
                    r_point_valid <= 1'b1;
                    r_state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_point_valid <= 1'b0;
                    r_steps       <= r_steps + 8'd1;
                    r_cnt         <= LAT_M1;
                    r_state       <= S_WAIT;
                end
                S_WAIT: if (r_cnt == 8'd0) begin
                    r_dist  <= i_distance;
                    r_state <= S_UPDATE;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                S_UPDATE: if (w_hit) begin
                    r_hit        <= 1'b1;
                    r_t_out      <= r_t;
                    r_done_valid <= 1'b1;
                    r_state      <= S_DONE;
                end else if (w_far || w_last) begin
                    r_hit        <= 1'b0;
                    r_t_out      <= w_t_next;
                    r_done_valid <= 1'b1;
                    r_state      <= S_DONE;
                end else begin
                    r_t     <= w_t_next;
                    r_state <= S_POINT;
                end
                S_DONE: if (i_done_ready) begin
                    r_done_valid <= 1'b0;
                    r_ray_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ray_ready   = r_ray_ready;
    assign o_point_x     = r_px;
    assign o_point_y     = r_py;
    assign o_point_z     = r_pz;
    assign o_point_valid = r_point_valid;
    assign o_done_valid  = r_done_valid;
    assign o_hit         = r_hit;
    assign o_t           = r_t_out;
    assign o_steps       = r_steps;

endmodule

// File: tb/tb_raymarch_stepper.sv
// Directed bench for raymarch_stepper with a behavioural delayed SDF (sphere / constant / negative-first).
module tb_raymarch_stepper;

    localparam int LAT = 4;
    localparam logic [26:0] ONE      = 27'h1FC0000;
    localparam logic [26:0] QUARTER  = 27'h1F40000;
    localparam logic [26:0] NEG_HALF = 27'h5F80000;
    localparam logic [26:0] NEG_3    = 27'h6020000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_ray_valid;
    logic        o_ray_ready;
    logic [26:0] i_origin_x, i_origin_y, i_origin_z;
    logic [26:0] i_dir_x, i_dir_y, i_dir_z;
    logic [26:0] o_point_x, o_point_y, o_point_z;
    logic        o_point_valid;
    logic [26:0] i_distance;
    logic        o_done_valid;
    logic        i_done_ready;
    logic        o_hit;
    logic [26:0] o_t;
    logic [7:0]  o_steps;

    int n_cmp = 0;
    int n_bad = 0;

    int          sdf_mode  = 1;
    logic [26:0] sdf_const = ONE;
    logic [26:0] px_p[LAT] = '{default: 27'h0};
    logic [26:0] py_p[LAT] = '{default: 27'h0};
    logic [26:0] pz_p[LAT] = '{default: 27'h0};
    int          idx_p[LAT] = '{default: 0};
    int          n_issue = 0;

    always #5 clk = ~clk;

    raymarch_stepper dut (
        .clk(clk), .reset(reset),
        .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready),
        .i_origin_x(i_origin_x), .i_origin_y(i_origin_y), .i_origin_z(i_origin_z),
        .i_dir_x(i_dir_x), .i_dir_y(i_dir_y), .i_dir_z(i_dir_z),
        .o_point_x(o_point_x), .o_point_y(o_point_y), .o_point_z(o_point_z),
        .o_point_valid(o_point_valid), .i_distance(i_distance),
        .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
        .o_hit(o_hit), .o_t(o_t), .o_steps(o_steps)
    );

    function automatic real f2r(input logic [26:0] f);
        real v;
        int  e;
        if (f[25:18] == 8'd0) return 0.0;
        v = 1.0 + real'(f[17:0]) / 262144.0;
        e = int'(f[25:18]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[26] ? -v : v;
    endfunction

    function automatic logic [26:0] r2f(input real r);
        real         a;
        int          e;
        logic [17:0] m;
        logic        s;
        if (r == 0.0) return 27'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = 18'($rtoi((a - 1.0) * 262144.0));
        return {s, 8'(e), m};
    endfunction

    // SDF pipeline keeps running through reset, like the real evaluator would.
    always @(posedge clk) begin
        px_p[0]  <= o_point_x;
        py_p[0]  <= o_point_y;
        pz_p[0]  <= o_point_z;
        idx_p[0] <= o_point_valid ? n_issue + 1 : 0;
        for (int k = 1; k < LAT; k++) begin
            px_p[k]  <= px_p[k-1];
            py_p[k]  <= py_p[k-1];
            pz_p[k]  <= pz_p[k-1];
            idx_p[k] <= idx_p[k-1];
        end
        if (i_ray_valid && o_ray_ready) n_issue <= 0;
        else if (o_point_valid)         n_issue <= n_issue + 1;
    end

    always_comb begin
        real x, y, z;
        x = f2r(px_p[LAT-1]);
        y = f2r(py_p[LAT-1]);
        z = f2r(pz_p[LAT-1]);
        case (sdf_mode)
            0:       i_distance = r2f($sqrt(x*x + y*y + z*z) - 1.0);
            1:       i_distance = sdf_const;
            default: i_distance = (idx_p[LAT-1] == 1) ? NEG_HALF : 27'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_ray(output int first_pv, output int done_cyc, output logic [26:0] pz2);
        int cyc;
        int nv;
        @(negedge clk);
        i_origin_x = 27'h0; i_origin_y = 27'h0; i_origin_z = NEG_3;
        i_dir_x = 27'h0;    i_dir_y = 27'h0;    i_dir_z = ONE;
        i_ray_valid = 1'b1;
        @(negedge clk);
        i_ray_valid = 1'b0;
        cyc = 1; nv = 0; first_pv = -1; pz2 = 27'h0;
        while (!o_done_valid && cyc < 1000) begin
            if (o_point_valid) begin
                nv++;
                if (first_pv < 0) first_pv = cyc;
                if (nv == 2) pz2 = o_point_z;
            end
            @(negedge clk);
            cyc++;
        end
        done_cyc = cyc;
        chk("done_timeout", 32'(o_done_valid), 32'd1);
    endtask

    task automatic release_done();
        i_done_ready = 1'b1;
        @(negedge clk);
        i_done_ready = 1'b0;
        chk("ready_after_done", 32'(o_ray_ready), 32'd1);
        chk("done_cleared", 32'(o_done_valid), 32'd0);
    endtask

    initial begin
        int          fpv, dcyc, nv, bp_bad, late_bad;
        logic [26:0] pz2, t0;
        logic [7:0]  s0;

        reset = 1'b1; i_ray_valid = 1'b0; i_done_ready = 1'b0;
        i_origin_x = 27'h0; i_origin_y = 27'h0; i_origin_z = 27'h0;
        i_dir_x = 27'h0; i_dir_y = 27'h0; i_dir_z = 27'h0;
        repeat (2) @(negedge clk);
        chk("rst_ray_ready", 32'(o_ray_ready), 32'd1);
        chk("rst_point_valid", 32'(o_point_valid), 32'd0);
        chk("rst_done_valid", 32'(o_done_valid), 32'd0);
        chk("rst_t", 32'(o_t), 32'd0);
        chk("rst_steps", 32'(o_steps), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Sphere of radius 1 at the origin, ray from z=-3.
        sdf_mode = 0;
        run_ray(fpv, dcyc, pz2);
        chk("sph_first_pv_cycle", 32'(fpv), 32'd2);
        chk("sph_done_cycle", 32'(dcyc), 32'd15);
        chk("sph_point2_z", 32'(pz2), 32'h5FC0000);
        chk("sph_hit", 32'(o_hit), 32'd1);
        chk("sph_t", 32'(o_t), 32'h2000000);
        chk("sph_steps", 32'(o_steps), 32'd2);
        release_done();

        // Far-plane miss plus result backpressure.
        sdf_mode = 1; sdf_const = ONE;
        run_ray(fpv, dcyc, pz2);
        chk("far_done_cycle", 32'(dcyc), 32'd232);
        chk("far_hit", 32'(o_hit), 32'd0);
        chk("far_t", 32'(o_t), 32'h2102000);
        chk("far_steps", 32'(o_steps), 32'd33);
        t0 = o_t; s0 = o_steps; bp_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(o_done_valid && o_t == t0 && o_steps == s0 && !o_ray_ready)) bp_bad++;
        end
        chk("bp_stable", 32'(bp_bad), 32'd0);
        release_done();

        // Step-limit miss.
        sdf_const = QUARTER;
        run_ray(fpv, dcyc, pz2);
        chk("lim_done_cycle", 32'(dcyc), 32'd449);
        chk("lim_hit", 32'(o_hit), 32'd0);
        chk("lim_t", 32'(o_t), 32'h20C0000);
        chk("lim_steps", 32'(o_steps), 32'd64);
        release_done();

        // Negative distance on the first sample, zero afterwards.
        sdf_mode = 2;
        run_ray(fpv, dcyc, pz2);
        chk("neg_hit", 32'(o_hit), 32'd1);
        chk("neg_t", 32'(o_t), 32'd0);
`ifdef RAYMARCH_NEG_HIT_EN
        chk("neg_steps", 32'(o_steps), 32'd1);
`else
        chk("neg_steps", 32'(o_steps), 32'd2);
        chk("neg_point2_z", 32'(pz2), 32'(NEG_3));
`endif
        release_done();

        // Reset during WAIT of step 3; a late zero distance must not produce a result.
        sdf_mode = 1; sdf_const = ONE;
        @(negedge clk);
        i_origin_x = 27'h0; i_origin_y = 27'h0; i_origin_z = NEG_3;
        i_dir_x = 27'h0; i_dir_y = 27'h0; i_dir_z = ONE;
        i_ray_valid = 1'b1;
        @(negedge clk);
        i_ray_valid = 1'b0;
        nv = 0;
        for (int c = 0; c < 100 && nv < 3; c++) begin
            @(negedge clk);
            if (o_point_valid) nv++;
        end
        chk("rst3_reached_step3", 32'(nv), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        sdf_const = 27'h0;
        #1;
        chk("mid_ray_ready", 32'(o_ray_ready), 32'd1);
        chk("mid_point_valid", 32'(o_point_valid), 32'd0);
        chk("mid_done_valid", 32'(o_done_valid), 32'd0);
        chk("mid_hit", 32'(o_hit), 32'd0);
        chk("mid_t", 32'(o_t), 32'd0);
        chk("mid_steps", 32'(o_steps), 32'd0);
        chk("mid_point_z", 32'(o_point_z), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        late_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_done_valid || !o_ray_ready) late_bad++;
        end
        chk("late_dist_ignored", 32'(late_bad), 32'd0);

        sdf_mode = 0;
        run_ray(fpv, dcyc, pz2);
        chk("post_rst_hit", 32'(o_hit), 32'd1);
        chk("post_rst_t", 32'(o_t), 32'h2000000);
        chk("post_rst_steps", 32'(o_steps), 32'd2);
        release_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
